// File: rtl/div_r32m_pkg.sv
// Shared definitions for the RV32M divide/remainder unit: ALU operation codes
// for the divide family and the latched operation type.
package div_r32m_pkg;

    // Divide-family ALU codes; chosen clear of the existing base ALU codes.
    localparam logic [4:0] ALU_DIV  = 5'd20;
    localparam logic [4:0] ALU_DIVU = 5'd21;
    localparam logic [4:0] ALU_REM  = 5'd22;
    localparam logic [4:0] ALU_REMU = 5'd23;

    typedef enum logic [1:0] {
        OP_DIV,
        OP_DIVU,
        OP_REM,
        OP_REMU
    } div_op_e;

    function automatic logic is_div_code(input logic [4:0] code);
        return code inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    function automatic div_op_e decode_op(input logic [4:0] code);
        case (code)
            ALU_DIVU: return OP_DIVU;
            ALU_REM:  return OP_REM;
            ALU_REMU: return OP_REMU;
            default:  return OP_DIV;
        endcase
    endfunction

endpackage

// File: rtl/div_r32m_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract
// the divisor, keep the difference when it does not go negative.
module div_r32m_step #(
    parameter int unsigned dataW = 32
) (
    input  logic [dataW-1:0] rem,
    input  logic             dbit,
    input  logic [dataW-1:0] divisor,
    output logic [dataW-1:0] rem_next,
    output logic             q_bit
);

    logic [dataW:0] shifted;
    logic [dataW:0] diff;

    always_comb begin
        shifted  = {rem, dbit};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[dataW];
        rem_next = q_bit ? diff[dataW-1:0] : shifted[dataW-1:0];
    end

endmodule

// File: rtl/div_r32m.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit with start/busy/done handshake.
// dataW restoring iterations followed by one sign-fix cycle.
module div_r32m
    import div_r32m_pkg::*;
#(
    parameter int unsigned dataW = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       ALUCode,
    input  logic [dataW-1:0] A,
    input  logic [dataW-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [dataW-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;
    localparam int unsigned CW = $clog2(dataW);

    state_e           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [dataW-1:0] rem, quo, dvsr, a_raw;
    div_op_e          op;
    logic             neg_q, neg_r, div0, ovf;

    logic             accept, last, sgn, q_bit;
    logic [dataW-1:0] rem_nxt, abs_a, abs_b, q_fix, r_fix, res_fix;

    div_r32m_step #(.dataW(dataW)) u_step (
        .rem      (rem),
        .dbit     (quo[dataW-1]),
        .divisor  (dvsr),
        .rem_next (rem_nxt),
        .q_bit    (q_bit)
    );

    assign accept = (state == IDLE) && start && is_div_code(ALUCode);
    assign last   = (cnt == CW'(dataW - 1));
    assign sgn    = (ALUCode == ALU_DIV) || (ALUCode == ALU_REM);
    assign abs_a  = A[dataW-1] ? -A : A;
    assign abs_b  = B[dataW-1] ? -B : B;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    if (last)   state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        q_fix = neg_q ? -quo : quo;
        r_fix = neg_r ? -rem : rem;
        case (op)
            OP_DIV:  res_fix = div0 ? '1 : (ovf ? a_raw : q_fix);
            OP_DIVU: res_fix = div0 ? '1 : quo;
            OP_REM:  res_fix = div0 ? a_raw : (ovf ? '0 : r_fix);
            default: res_fix = div0 ? a_raw : rem;
        endcase
    end

    // quo starts as the dividend and fills with quotient bits as it shifts out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            a_raw  <= '0;
            op     <= OP_DIV;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            ovf    <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= (state == FIX);
            if (accept) begin
                op    <= decode_op(ALUCode);
                neg_q <= sgn & (A[dataW-1] ^ B[dataW-1]);
                neg_r <= sgn & A[dataW-1];
                quo   <= sgn ? abs_a : A;
                dvsr  <= sgn ? abs_b : B;
                rem   <= '0;
                cnt   <= '0;
                a_raw <= A;
                div0  <= (B == '0);
                ovf   <= sgn && (A == {1'b1, {(dataW-1){1'b0}}}) && (B == '1);
            end else if (state == CALC) begin
                rem <= rem_nxt;
                quo <= {quo[dataW-2:0], q_bit};
                cnt <= cnt + CW'(1);
            end else if (state == FIX) begin
                result <= res_fix;
            end
        end
    end

endmodule

// File: tb/tb_div_r32m.sv
// Self-checking bench for div_r32m: arithmetic reference model with a
// per-cycle compare of busy/done/result plus directed literal expectations.
module tb_div_r32m;
    import div_r32m_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  ALUCode = '0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy, done;
    logic [31:0] result;

    int n_checks = 0;
    int n_err = 0;

    div_r32m #(.dataW(32)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .ALUCode (ALUCode),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Architectural result of one operation, from RV32M rules.
    function automatic logic [31:0] model_div(input logic [4:0] code,
                                              input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        logic ov;
        sa = a;
        sb = b;
        ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (code)
            ALU_DIV:  return (b == 0) ? 32'hFFFF_FFFF : (ov ? a : 32'(sa / sb));
            ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REM:  return (b == 0) ? a : (ov ? 32'h0 : 32'(sa % sb));
            default:  return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycle-level expectation: an accepted op completes 33 edges later.
    int          m_cnt = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_result = '0;
    logic [31:0] m_pend = '0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_cnt = 0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_result = '0;
        end else begin
            m_done = 1'b0;
            if (m_cnt != 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_done = 1'b1;
                    m_busy = 1'b0;
                    m_result = m_pend;
                end
            end else if (start && is_div_code(ALUCode)) begin
                m_cnt = 33;
                m_busy = 1'b1;
                m_pend = model_div(ALUCode, A, B);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            #1;
            chk("busy", {31'b0, busy}, {31'b0, m_busy});
            chk("done", {31'b0, done}, {31'b0, m_done});
            chk("result", result, m_result);
        end
    end

    // Called at a negedge; returns at the negedge where done is high.
    task automatic run_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit, input string name);
        int k;
        ALUCode = code;
        A = a;
        B = b;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clock);
            k++;
        end
        chk({name, " latency"}, k, 33);
        chk(name, result, lit);
    endtask

    int          ndone;
    logic [31:0] last_res;

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b0;

        chk("model div 20/6", model_div(ALU_DIV, 32'd20, 32'd6), 32'd3);
        chk("model rem -7/2", model_div(ALU_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        chk("model div ovf", model_div(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        chk("model remu b0", model_div(ALU_REMU, 32'd9, 32'd0), 32'd9);

        ALUCode = 5'd0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        chk("ignored code busy", {31'b0, busy}, 32'd0);

        run_op(ALU_DIV,  32'd20,          32'd6,           32'd3,           "div 20/6");
        run_op(ALU_REM,  32'd20,          32'd6,           32'd2,           "rem 20/6");
        run_op(ALU_DIV,  32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD,   "div -7/2");
        run_op(ALU_REM,  32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF,   "rem -7/2");
        run_op(ALU_REM,  32'd7,           32'hFFFF_FFFE,   32'd1,           "rem 7/-2");
        run_op(ALU_DIVU, 32'hFFFF_FFFE,   32'd2,           32'h7FFF_FFFF,   "divu");
        run_op(ALU_REMU, 32'hFFFF_FFFE,   32'hFFFF_FFFF,   32'hFFFF_FFFE,   "remu");
        run_op(ALU_DIV,  32'd9,           32'd0,           32'hFFFF_FFFF,   "div by 0");
        run_op(ALU_REMU, 32'd9,           32'd0,           32'd9,           "remu by 0");
        run_op(ALU_DIV,  32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   "div ovf");
        run_op(ALU_REM,  32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           "rem ovf");
        repeat (2) @(negedge clock);

        ALUCode = ALU_DIV;
        A = 32'd20;
        B = 32'd6;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        A = 32'd100;
        B = 32'd10;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        ndone = 0;
        last_res = '0;
        repeat (40) begin
            @(negedge clock);
            if (done === 1'b1) begin
                ndone++;
                last_res = result;
            end
        end
        chk("start-while-busy dones", ndone, 1);
        chk("start-while-busy result", last_res, 32'd3);

        A = 32'd20;
        B = 32'd6;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clock);
            if (done === 1'b1) ndone++;
        end
        chk("no done after reset", ndone, 0);
        run_op(ALU_DIV, 32'd20, 32'd6, 32'd3, "div after reset");
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
